// File: rtl/fifo.sv
// Synchronous FIFO with a circular buffer, registered read data and
// single-cycle overflow/underflow pulses.
module fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic             read,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             almost_full,
   output logic             full,
   output logic             over,
   output logic             empty,
   output logic             under,
   output logic             valid
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] COUNT_FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] COUNT_ALMOST = (AW+1)'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign full        = (count == COUNT_FULL);
   assign almost_full = (count >= COUNT_ALMOST);
   assign empty       = (count == '0);

   // A full FIFO drops writes and an empty one rejects reads, so a
   // simultaneous request only ever loses the side that cannot proceed.
   assign wr_ok = write && !full;
   assign rd_ok = read && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         valid  <= 1'b0;
         over   <= 1'b0;
         under  <= 1'b0;
      end else begin
         over  <= write && full;
         under <= read && empty;
         valid <= rd_ok;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the fifo block (WIDTH=16, DEPTH=8).
module tb_fifo;

   logic        clk;
   logic        reset;
   logic        write;
   logic        read;
   logic [15:0] din;
   logic [15:0] dout;
   logic        almost_full;
   logic        full;
   logic        over;
   logic        empty;
   logic        under;
   logic        valid;

   int checks;
   int failures;

   fifo #(.WIDTH(16), .DEPTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .write(write),
      .read(read),
      .din(din),
      .dout(dout),
      .almost_full(almost_full),
      .full(full),
      .over(over),
      .empty(empty),
      .under(under),
      .valid(valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic applyStimulus(input logic w, input logic r, input logic [15:0] d);
      @(negedge clk);
      write = w;
      read  = r;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_dout"}, 32'(dout), 32'h0);
      checkOutput({tag, "_empty"}, 32'(empty), 32'h1);
      checkOutput({tag, "_full"}, 32'(full), 32'h0);
      checkOutput({tag, "_afull"}, 32'(almost_full), 32'h0);
      checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
      checkOutput({tag, "_over"}, 32'(over), 32'h0);
      checkOutput({tag, "_under"}, 32'(under), 32'h0);
   endtask

   logic [15:0] read_seq [14];

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      write    = 1'b0;
      read     = 1'b0;
      din      = '0;
      read_seq = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8,
                   16'hB, 16'hC, 16'hD, 16'hE, 16'hF, 16'h10};

      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      reset = 1'b1;

      // Fill with 1..8 and watch the flags climb.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(i));
         checkOutput($sformatf("fill%0d_empty", i), 32'(empty), 32'h0);
         checkOutput($sformatf("fill%0d_afull", i), 32'(almost_full), (i >= 7) ? 32'h1 : 32'h0);
         checkOutput($sformatf("fill%0d_full", i), 32'(full), (i == 8) ? 32'h1 : 32'h0);
         checkOutput($sformatf("fill%0d_valid", i), 32'(valid), 32'h0);
      end

      // Overflow attempts are dropped and pulse over.
      applyStimulus(1'b1, 1'b0, 16'h9);
      checkOutput("ovf9_over", 32'(over), 32'h1);
      checkOutput("ovf9_full", 32'(full), 32'h1);
      applyStimulus(1'b1, 1'b0, 16'hA);
      checkOutput("ovfA_over", 32'(over), 32'h1);
      checkOutput("ovfA_full", 32'(full), 32'h1);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("ovf_idle_over", 32'(over), 32'h0);
      checkOutput("ovf_idle_full", 32'(full), 32'h1);

      // Drain: first read alone, then six read+write pairs, then reads only.
      for (int i = 0; i < 14; i++) begin
         if (i >= 1 && i <= 6) begin
            applyStimulus(1'b1, 1'b1, 16'(16'hA + i));
         end else begin
            applyStimulus(1'b0, 1'b1, 16'h0);
         end
         checkOutput($sformatf("drain%0d_dout", i), 32'(dout), 32'(read_seq[i]));
         checkOutput($sformatf("drain%0d_valid", i), 32'(valid), 32'h1);
         checkOutput($sformatf("drain%0d_over", i), 32'(over), 32'h0);
      end
      checkOutput("drain_empty", 32'(empty), 32'h1);
      applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("udf_under", 32'(under), 32'h1);
      checkOutput("udf_valid", 32'(valid), 32'h0);
      checkOutput("udf_dout", 32'(dout), 32'h10);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("udf_idle_under", 32'(under), 32'h0);

      // Reset again so dout starts at zero for the simultaneous-from-empty case.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 16'h1234);
      checkOutput("rw_empty_under", 32'(under), 32'h1);
      checkOutput("rw_empty_valid", 32'(valid), 32'h0);
      checkOutput("rw_empty_dout", 32'(dout), 32'h0);
      checkOutput("rw_empty_empty", 32'(empty), 32'h0);
      applyStimulus(1'b1, 1'b1, 16'h5678);
      checkOutput("rw_one_dout", 32'(dout), 32'h1234);
      checkOutput("rw_one_valid", 32'(valid), 32'h1);
      checkOutput("rw_one_under", 32'(under), 32'h0);
      checkOutput("rw_one_empty", 32'(empty), 32'h0);
      checkOutput("rw_one_afull", 32'(almost_full), 32'h0);
      applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("rw_last_dout", 32'(dout), 32'h5678);
      checkOutput("rw_last_empty", 32'(empty), 32'h1);

      // Read and write together while full.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(i));
      end
      checkOutput("refill_full", 32'(full), 32'h1);
      applyStimulus(1'b1, 1'b1, 16'h99);
      checkOutput("rw_full_dout", 32'(dout), 32'h1);
      checkOutput("rw_full_valid", 32'(valid), 32'h1);
      checkOutput("rw_full_over", 32'(over), 32'h1);
      checkOutput("rw_full_full", 32'(full), 32'h0);
      checkOutput("rw_full_afull", 32'(almost_full), 32'h1);

      // Asynchronous reset between clock edges while holding data and pulses.
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      checkResetState("async");
      @(negedge clk);
      reset = 1'b1;

      // First write after reset release is accepted and reads back first.
      applyStimulus(1'b1, 1'b0, 16'h77);
      checkOutput("post_empty", 32'(empty), 32'h0);
      applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("post_dout", 32'(dout), 32'h77);
      checkOutput("post_valid", 32'(valid), 32'h1);
      checkOutput("post_drained", 32'(empty), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits.
REQ-002 Parameter DEPTH, default 8: number of storage entries; power of two.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 write  input  1  write request; din is sampled on the same rising edge.
REQ-006 read  input  1  read request.
REQ-007 din  input  WIDTH  write data.
REQ-008 dout  output  WIDTH  registered read data.
REQ-009 almost_full  output  1  occupancy >= DEPTH-1.
REQ-010 full  output  1  occupancy == DEPTH.
REQ-011 over  output  1  registered overflow pulse.
REQ-012 empty  output  1  occupancy == 0.
REQ-013 under  output  1  registered underflow pulse.
REQ-014 valid  output  1  registered pulse meaning dout was updated by an accepted read.

Function
REQ-015 Storage SHALL be a circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
REQ-016 Ordering SHALL be strict first-in first-out.
REQ-017 full, almost_full and empty SHALL be decoded combinationally from the registered count, so they reflect each edge's update immediately.
REQ-018 An accepted write SHALL store din at the write pointer and advance the pointer.
REQ-019 An accepted read SHALL load dout with the entry at the read pointer, advance that pointer, and set valid=1 for the following cycle.
REQ-020 Read latency SHALL be one cycle: data is visible on dout after the rising edge on which read was sampled.
REQ-021 On cycles with no accepted read, dout SHALL hold its previous value and valid SHALL be 0.
REQ-022 Write only, not full: write accepted; count+1.
REQ-023 Write only, full: write discarded; count and memory unchanged; over=1 for the next cycle.
REQ-024 Read only, not empty: read accepted; count-1.
REQ-025 Read only, empty: read rejected; dout held; valid=0; under=1 for the next cycle.
REQ-026 Read and write, 0 < count < DEPTH: both accepted; count unchanged.
REQ-027 Read and write, empty: write accepted, read rejected; count becomes 1; under=1; valid=0.
REQ-028 Read and write, full: read accepted, write discarded; count becomes DEPTH-1; over=1; valid=1.
REQ-029 over and under SHALL be single-cycle pulses: cleared on any edge without the corresponding error condition.

Reset
REQ-030 While reset is low, the block SHALL hold this state: dout=0, pointers=0, count=0, over=0, under=0, valid=0, so empty=1, full=0 and almost_full=0.
REQ-031 Assertion SHALL take effect immediately, without waiting for a clock edge, including mid-operation.
REQ-032 Memory contents need not be cleared.
REQ-033 The first write is accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Scenario: after reset, write 1..8 on consecutive cycles -> empty=0 after the first write; almost_full=1 after the 7th; full=1 after the 8th.
REQ-035 Scenario: full, then write 9 and 0xA on consecutive cycles -> over=1 after each write with full=1; over=0 once write is dropped; neither value is stored.
REQ-036 Scenario: read continuously while interleaving writes of 0xB..0x10 -> dout sequence 1,2,...,8,0xB,...,0x10 with valid=1 on each; empty=1 after 0x10; one more read -> under=1, valid=0, dout stays 0x10.
REQ-037 Scenario: from empty, read and write 0x1234 together -> under=1, valid=0, dout=0, empty=0; the next read+write cycle -> dout=0x1234, valid=1, count stays 1.
REQ-038 Scenario: fill with 8 entries (first = 1), then read and write together -> dout=1, valid=1, over=1, full=0, almost_full=1.
REQ-039 Scenario: pull reset low asynchronously while the FIFO holds data -> all outputs return to their reset values at once, without a clock edge.
